message_scroller: RTL

- Upstream scroll controller for the 16x8 message ROM. It generates the ROM's 4-bit address, reads a 6-character window starting at a scroll base pointer, and presents that window to the six HEX display decoders.
- Every scroll period the base pointer advances by one, modulo 16, which produces a continuously rotating marquee.
- The ROM is combinational, so data returned in a cycle belongs to the address driven in that same cycle.

---
 rtl/message_scroller.sv | 92 +++++++++
 1 files changed

// File: rtl/message_scroller.sv
// Marquee controller: fills a 6-character shadow window from the message ROM, commits it
// atomically, then waits TICK_DIV run-cycles before advancing the base. Optional macro SCROLL_DIR_EN adds dir.
module message_scroller #(
   parameter int TICK_DIV   = 25000000,
   parameter int NUM_DIGITS = 6
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    run,
`ifdef SCROLL_DIR_EN
   input  logic                    dir,
`endif
   output logic [3:0]              rom_addr,
   input  logic [7:0]              rom_data,
   output logic [8*NUM_DIGITS-1:0] window,
   output logic                    frame_valid,
   output logic [3:0]              base_ptr
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);

   typedef enum logic [1:0] {ST_FILL, ST_COMMIT, ST_WAIT} state_t;

   state_t           state;
   logic [3:0]       base;
   logic [IDX_W-1:0] idx;
   logic [CNT_W-1:0] cnt;
   logic [7:0]       shadow [NUM_DIGITS];

   // The ROM answers combinationally, so the address is decoded from the current state.
   always_comb begin
      rom_addr = base;
      if (state == ST_FILL)
         rom_addr = base + 4'(idx);
   end

   assign base_ptr = base;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_FILL;
         base        <= 4'd0;
         idx         <= '0;
         cnt         <= '0;
         window      <= {NUM_DIGITS{8'h20}};
         frame_valid <= 1'b0;
         for (int i = 0; i < NUM_DIGITS; i++)
            shadow[i] <= 8'h20;
      end else begin
         frame_valid <= 1'b0;
         case (state)
            ST_FILL: begin
               shadow[idx] <= rom_data;
               if (idx == IDX_LAST) begin
                  idx   <= '0;
                  state <= ST_COMMIT;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            ST_COMMIT: begin
               // shadow[0] holds ROM[base] and lands on the leftmost digit.
               for (int i = 0; i < NUM_DIGITS; i++)
                  window[8*(NUM_DIGITS-1-i) +: 8] <= shadow[i];
               frame_valid <= 1'b1;
               cnt         <= '0;
               state       <= ST_WAIT;
            end
            ST_WAIT: begin
               if (run) begin
                  if (cnt == TICK_LAST) begin
                     cnt   <= '0;
                     state <= ST_FILL;
`ifdef SCROLL_DIR_EN
                     base  <= dir ? base - 4'd1 : base + 4'd1;
`else
                     base  <= base + 4'd1;
`endif
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            default: state <= ST_FILL;
         endcase
      end
   end

endmodule
